// File: rtl/control_multiciclo_pkg.sv
// control_multiciclo_pkg
// Shared definitions for the multicycle RV32I control path: FSM state
// encoding, opcode constants, ALU operation codes and every mux-select
// encoding the datapath agrees on, plus the opcode -> immediate-format map.
package control_multiciclo_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_ADDR,
        S_MEM,
        S_BRANCH,
        S_JUMP,
        S_ERROR
    } state_t;

    // Which rule the ALU decoder applies in the current state.
    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_EXEC,
        CLS_BRANCH
    } alu_cls_t;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0110;

    localparam logic [1:0] A_RS1    = 2'b00;
    localparam logic [1:0] A_PC     = 2'b01;
    localparam logic [1:0] A_PC_OLD = 2'b10;
    localparam logic [1:0] A_ZERO   = 2'b11;

    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    localparam logic ADDR_PC     = 1'b0;
    localparam logic ADDR_ALUOUT = 1'b1;

    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;

    function automatic logic [2:0] imm_for_opcode(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_LUI, OP_AUIPC: return IMM_U;
            OP_JAL:           return IMM_J;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/control_multiciclo_decodificador_alu.sv
// decodificador_alu
// Combinational ALU operation decoder.
//   cls     : decoding rule selected by the FSM state
//   opcode  : instr[6:0]
//   funct3  : instr[14:12]
//   bit30   : instr[30] (SUB/SRA modifier)
//   alu_sel : {funct3, mod} operation code for the datapath ALU
module decodificador_alu
    import control_multiciclo_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       bit30,
    output logic [3:0] alu_sel
);

    always_comb begin
        alu_sel = ALU_ADD;
        case (cls)
            CLS_EXEC: begin
                if (opcode == OP_OP) begin
                    alu_sel = {funct3, bit30};
                end else if (opcode == OP_IMM) begin
                    // instr[30] is an immediate bit for every OP-IMM except the shifts-right.
                    alu_sel = {funct3, (funct3 == 3'b101) ? bit30 : 1'b0};
                end
            end
            CLS_BRANCH: begin
                // BEQ/BNE compare by subtraction; BLT/BGE/BLTU/BGEU by SLT/SLTU.
                alu_sel = funct3[2] ? {2'b01, funct3[1], 1'b0} : ALU_SUB;
            end
            default: alu_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// control_multiciclo
// Multicycle control FSM for the RV32I core.
//   clk, reset       : clock (rising edge), synchronous active-high reset
//   instr            : instruction register contents
//   cero             : datapath ALU result == 0
//   mem_ready        : memory completes the current transfer
//   mem_valid/mem_we : memory request / request is a store
//   mem_addr_sel     : memory address source (PC / ALU-out)
//   ir_we, pc_we     : IR+pc_old load, PC write
//   pc_src           : PC source (live ALU / ALU-out)
//   alu_sel/_a_sel/_b_sel, imm_type : ALU operation and operand selects
//   reg_we, wb_sel   : register-file write and write-back source
//   error            : sticky illegal-instruction trap
module control_multiciclo
    import control_multiciclo_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        cero,
    input  logic        mem_ready,
    output logic        mem_valid,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic [3:0]  alu_sel,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [2:0]  imm_type,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        error
);

    state_t   state;
    alu_cls_t alu_cls;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_load;
    logic       is_store;
    logic       branch_taken;
    logic       branch_illegal;
    logic       unused_instr_bits;

    assign opcode         = instr[6:0];
    assign funct3         = instr[14:12];
    assign is_load        = (opcode == OP_LOAD);
    assign is_store       = (opcode == OP_STORE);
    // cero says "equal" for SUB and "not less" for SLT/SLTU; funct3[0] inverts the sense.
    assign branch_taken   = cero ^ funct3[0] ^ funct3[2];
    assign branch_illegal = (funct3[2:1] == 2'b01);
    // Register and immediate fields are consumed by the datapath only.
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    decodificador_alu u_alu_dec (
        .cls     (alu_cls),
        .opcode  (opcode),
        .funct3  (funct3),
        .bit30   (instr[30]),
        .alu_sel (alu_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JALR: state <= S_EXEC;
                        OP_LOAD, OP_STORE: state <= S_ADDR;
                        OP_BRANCH:         state <= S_BRANCH;
                        OP_JAL:            state <= S_JUMP;
                        OP_MISC_MEM:       state <= S_FETCH;
                        default:           state <= S_ERROR;
                    endcase
                end
                S_EXEC:   state <= (opcode == OP_JALR) ? S_JUMP : S_WB;
                S_WB:     state <= S_FETCH;
                S_ADDR:   state <= S_MEM;
                S_MEM:    if (mem_ready) state <= is_load ? S_WB : S_FETCH;
                S_BRANCH: state <= branch_illegal ? S_ERROR : S_FETCH;
                S_JUMP:   state <= S_FETCH;
                S_ERROR:  state <= S_ERROR;
                default:  state <= S_ERROR;
            endcase
        end
    end

    // Outputs are decoded from the state and forced to 0 while reset is high,
    // so a request in flight is dropped in the reset cycle itself.
    always_comb begin
        mem_valid    = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = ADDR_PC;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_SRC_ALU;
        alu_cls      = CLS_ADD;
        alu_a_sel    = A_RS1;
        alu_b_sel    = B_RS2;
        imm_type     = IMM_I;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        error        = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_valid = 1'b1;
                    alu_a_sel = A_PC;
                    alu_b_sel = B_FOUR;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                S_DECODE: begin
                    alu_a_sel = A_PC_OLD;
                    alu_b_sel = B_IMM;
                    imm_type  = imm_for_opcode(opcode);
                end
                S_EXEC: begin
                    alu_cls = CLS_EXEC;
                    case (opcode)
                        OP_OP: begin
                            alu_a_sel = A_RS1;
                            alu_b_sel = B_RS2;
                        end
                        OP_LUI: begin
                            alu_a_sel = A_ZERO;
                            alu_b_sel = B_IMM;
                            imm_type  = IMM_U;
                        end
                        OP_AUIPC: begin
                            alu_a_sel = A_PC_OLD;
                            alu_b_sel = B_IMM;
                            imm_type  = IMM_U;
                        end
                        default: begin
                            // OP-IMM and JALR: rs1 + I-immediate
                            alu_a_sel = A_RS1;
                            alu_b_sel = B_IMM;
                            imm_type  = IMM_I;
                        end
                    endcase
                end
                S_WB: begin
                    reg_we = 1'b1;
                    wb_sel = is_load ? WB_MEM : WB_ALU;
                end
                S_ADDR: begin
                    alu_a_sel = A_RS1;
                    alu_b_sel = B_IMM;
                    imm_type  = is_store ? IMM_S : IMM_I;
                end
                S_MEM: begin
                    mem_valid    = 1'b1;
                    mem_addr_sel = ADDR_ALUOUT;
                    mem_we       = is_store;
                end
                S_BRANCH: begin
                    alu_cls   = CLS_BRANCH;
                    alu_a_sel = A_RS1;
                    alu_b_sel = B_RS2;
                    pc_we     = branch_taken & ~branch_illegal;
                    pc_src    = branch_taken & ~branch_illegal;
                end
                S_JUMP: begin
                    // ALU-out holds the JAL target from DECODE or the JALR target from EXEC.
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_ALUOUT;
                    reg_we = 1'b1;
                    wb_sel = WB_PC;
                end
                S_ERROR: error = 1'b1;
                default: error = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_control_multiciclo.sv
// Testbench for control_multiciclo. Each driven cycle pushes the expected
// output vector to a scoreboard; the monitor pops and compares it on the
// falling edge of the same cycle.
module tb_control_multiciclo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        cero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_valid, mem_we, mem_addr_sel, ir_we, pc_we, pc_src;
    logic [3:0]  alu_sel;
    logic [1:0]  alu_a_sel, alu_b_sel;
    logic [2:0]  imm_type;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        error;

    control_multiciclo dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .cero         (cero),
        .mem_ready    (mem_ready),
        .mem_valid    (mem_valid),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_sel      (alu_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .imm_type     (imm_type),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .error        (error)
    );

    always #5 clk = ~clk;

    // {mem_valid, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_sel,
    //  alu_a_sel, alu_b_sel, imm_type, reg_we, wb_sel, error}
    logic [20:0] got;
    assign got = {mem_valid, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_sel,
                  alu_a_sel, alu_b_sel, imm_type, reg_we, wb_sel, error};

    typedef struct {
        string       tag;
        logic [20:0] exp;
    } sb_t;
    sb_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] cur_instr = 32'h0;

    task automatic check(input string tag, input logic [20:0] act, input logic [20:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [20:0] v(input logic mv, input logic mw, input logic ma,
                                      input logic irw, input logic pcw, input logic pcs,
                                      input logic [3:0] alu, input logic [1:0] a,
                                      input logic [1:0] b, input logic [2:0] imm,
                                      input logic rw, input logic [1:0] wb, input logic err);
        return {mv, mw, ma, irw, pcw, pcs, alu, a, b, imm, rw, wb, err};
    endfunction

    function automatic logic [20:0] f_fetch(input logic rdy);
        return v(1, 0, 0, rdy, rdy, 0, 4'b0000, 2'b01, 2'b10, 3'd0, 0, 2'b00, 0);
    endfunction
    function automatic logic [20:0] f_dec(input logic [2:0] imm);
        return v(0, 0, 0, 0, 0, 0, 4'b0000, 2'b10, 2'b01, imm, 0, 2'b00, 0);
    endfunction
    function automatic logic [20:0] f_wb(input logic [1:0] wb);
        return v(0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 3'd0, 1, wb, 0);
    endfunction
    function automatic logic [20:0] f_mem(input logic we);
        return v(1, we, 1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 3'd0, 0, 2'b00, 0);
    endfunction
    function automatic logic [20:0] f_jump();
        return v(0, 0, 0, 0, 1, 1, 4'b0000, 2'b00, 2'b00, 3'd0, 1, 2'b10, 0);
    endfunction
    function automatic logic [20:0] f_err();
        return v(0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 3'd0, 0, 2'b00, 1);
    endfunction

    // One clock cycle: inputs applied just after the rising edge.
    task automatic step(input string tag, input logic rst_i, input logic rdy,
                        input logic z, input logic [20:0] e);
        sb_t item;
        @(posedge clk);
        #1;
        reset     = rst_i;
        mem_ready = rdy;
        cero      = z;
        instr     = cur_instr;
        item.tag  = tag;
        item.exp  = e;
        sb.push_back(item);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t item;
            item = sb.pop_front();
            check(item.tag, got, item.exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step("reset", 1, 1, 0, 21'h0);

        // sub x3,x1,x2 ; ready in DECODE is not a request and is ignored
        cur_instr = 32'h402081B3;
        step("sub.fetch",  0, 1, 0, f_fetch(1));
        step("sub.decode", 0, 1, 0, f_dec(3'd0));
        step("sub.exec",   0, 0, 0, v(0,0,0,0,0,0,4'b0001,2'b00,2'b00,3'd0,0,2'b00,0));
        step("sub.wb",     0, 0, 0, f_wb(2'b00));

        // lw x5,8(x1) with two wait cycles in MEM
        cur_instr = 32'h0080A283;
        step("lw.fetch",  0, 1, 0, f_fetch(1));
        step("lw.decode", 0, 0, 0, f_dec(3'd0));
        step("lw.addr",   0, 0, 0, v(0,0,0,0,0,0,4'b0000,2'b00,2'b01,3'd0,0,2'b00,0));
        step("lw.mem0",   0, 0, 0, f_mem(0));
        step("lw.mem1",   0, 0, 0, f_mem(0));
        step("lw.mem2",   0, 1, 0, f_mem(0));
        step("lw.wb",     0, 0, 0, f_wb(2'b01));

        // sw x2,4(x1), zero wait
        cur_instr = 32'h0020A223;
        step("sw.fetch",  0, 1, 0, f_fetch(1));
        step("sw.decode", 0, 0, 0, f_dec(3'd1));
        step("sw.addr",   0, 0, 0, v(0,0,0,0,0,0,4'b0000,2'b00,2'b01,3'd1,0,2'b00,0));
        step("sw.mem",    0, 1, 0, f_mem(1));

        // bltu x1,x2,-8 taken (cero=0) then not taken (cero=1)
        cur_instr = 32'hFE20ECE3;
        step("bltu.fetch",  0, 1, 0, f_fetch(1));
        step("bltu.decode", 0, 0, 0, f_dec(3'd2));
        step("bltu.taken",  0, 0, 0, v(0,0,0,0,1,1,4'b0110,2'b00,2'b00,3'd0,0,2'b00,0));
        step("bltu2.fetch", 0, 1, 0, f_fetch(1));
        step("bltu2.decode",0, 0, 1, f_dec(3'd2));
        step("bltu.nottkn", 0, 0, 1, v(0,0,0,0,0,0,4'b0110,2'b00,2'b00,3'd0,0,2'b00,0));

        // beq x1,x2 with cero=1 is taken
        cur_instr = 32'h00208063;
        step("beq.fetch",  0, 1, 0, f_fetch(1));
        step("beq.decode", 0, 0, 1, f_dec(3'd2));
        step("beq.taken",  0, 0, 1, v(0,0,0,0,1,1,4'b0001,2'b00,2'b00,3'd0,0,2'b00,0));

        // srai x4,x4,3
        cur_instr = 32'h40325213;
        step("srai.fetch",  0, 1, 0, f_fetch(1));
        step("srai.decode", 0, 0, 0, f_dec(3'd0));
        step("srai.exec",   0, 0, 0, v(0,0,0,0,0,0,4'b1011,2'b00,2'b01,3'd0,0,2'b00,0));
        step("srai.wb",     0, 0, 0, f_wb(2'b00));

        // slli x4,x4,3
        cur_instr = 32'h00321213;
        step("slli.fetch",  0, 1, 0, f_fetch(1));
        step("slli.decode", 0, 0, 0, f_dec(3'd0));
        step("slli.exec",   0, 0, 0, v(0,0,0,0,0,0,4'b0010,2'b00,2'b01,3'd0,0,2'b00,0));
        step("slli.wb",     0, 0, 0, f_wb(2'b00));

        // lui x5,0x12345
        cur_instr = 32'h123452B7;
        step("lui.fetch",  0, 1, 0, f_fetch(1));
        step("lui.decode", 0, 0, 0, f_dec(3'd3));
        step("lui.exec",   0, 0, 0, v(0,0,0,0,0,0,4'b0000,2'b11,2'b01,3'd3,0,2'b00,0));
        step("lui.wb",     0, 0, 0, f_wb(2'b00));

        // jalr x1,0(x2)
        cur_instr = 32'h000100E7;
        step("jalr.fetch",  0, 1, 0, f_fetch(1));
        step("jalr.decode", 0, 0, 0, f_dec(3'd0));
        step("jalr.exec",   0, 0, 0, v(0,0,0,0,0,0,4'b0000,2'b00,2'b01,3'd0,0,2'b00,0));
        step("jalr.jump",   0, 0, 0, f_jump());

        // jal x1,16
        cur_instr = 32'h010000EF;
        step("jal.fetch",  0, 1, 0, f_fetch(1));
        step("jal.decode", 0, 0, 0, f_dec(3'd4));
        step("jal.jump",   0, 0, 0, f_jump());

        // fence: DECODE returns straight to FETCH
        cur_instr = 32'h0000000F;
        step("fence.fetch",  0, 1, 0, f_fetch(1));
        step("fence.decode", 0, 0, 0, f_dec(3'd0));

        // Reset while FETCH waits: no enables in the reset cycle, FETCH resumes
        cur_instr = 32'h402081B3;
        step("rstmid.wait",   0, 0, 0, f_fetch(0));
        step("rstmid.reset",  1, 1, 0, 21'h0);
        step("rstmid.fetch0", 0, 0, 0, f_fetch(0));
        step("rstmid.fetch1", 0, 1, 0, f_fetch(1));
        step("rstmid.decode", 0, 0, 0, f_dec(3'd0));
        step("rstmid.exec",   0, 0, 0, v(0,0,0,0,0,0,4'b0001,2'b00,2'b00,3'd0,0,2'b00,0));
        step("rstmid.wb",     0, 0, 0, f_wb(2'b00));

        // ecall: trap, sticky, cleared only by reset
        cur_instr = 32'h00000073;
        step("ecall.fetch",  0, 1, 0, f_fetch(1));
        step("ecall.decode", 0, 1, 0, f_dec(3'd0));
        step("ecall.err0",   0, 1, 1, f_err());
        step("ecall.err1",   0, 1, 0, f_err());
        step("ecall.err2",   0, 0, 0, f_err());
        step("ecall.reset",  1, 0, 0, 21'h0);
        step("ecall.fetch2", 0, 0, 0, f_fetch(0));

        // Branch with funct3=010 is illegal: no PC write, then trap
        cur_instr = 32'h0020A063;
        step("brill.fetch",  0, 1, 1, f_fetch(1));
        step("brill.decode", 0, 0, 1, f_dec(3'd2));
        step("brill.branch", 0, 0, 1, v(0,0,0,0,0,0,4'b0001,2'b00,2'b00,3'd0,0,2'b00,0));
        step("brill.err",    0, 1, 1, f_err());
        step("brill.reset",  1, 0, 0, 21'h0);

        @(negedge clk);
        @(negedge clk);
        check("drain", 21'(sb.size()), 21'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
